// File: rtl/spi_adc_responder.sv
// rtl/spi_adc_responder.sv - SPI peripheral model of a 16-bit serial ADC driving cipo
//
// Ports:
//   clk_in, rst_n_in     system clock, synchronous active-low reset
//   sample_in/_valid_in  sample source; sample_ready_out is high while the holding register is empty
//   chip_clk_in          SPI clock from the controller (idles high), oversampled
//   chip_sel_in          chip select from the controller (active low), oversampled
//   chip_data_out        serial data to the controller, MSB first
//   busy_out             frame in progress
//   frame_done_out       pulse: full word sent and CS released
//   frame_abort_out      pulse: CS released before the full word was sent
//   underrun_out         pulse: frame started with no fresh sample (last sample replayed)
module spi_adc_responder #(
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic                  sample_valid_in,
    output logic                  sample_ready_out,
    input  logic                  chip_clk_in,
    input  logic                  chip_sel_in,
    output logic                  chip_data_out,
    output logic                  busy_out,
    output logic                  frame_done_out,
    output logic                  frame_abort_out,
    output logic                  underrun_out
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Synchronizers preset high so reset never manufactures an edge.
    // sync_valid_q marks when the last stage holds a real pin sample.
    logic [SYNC_STAGES-1:0] sclk_sync_q, csn_sync_q, sync_valid_q;
    logic                   sclk_dly_q, csn_dly_q;
    logic                   sclk_s, csn_s;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign csn_s  = csn_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            sclk_sync_q  <= '1;
            csn_sync_q   <= '1;
            sync_valid_q <= '0;
            sclk_dly_q   <= 1'b1;
            csn_dly_q    <= 1'b1;
        end else begin
            sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], chip_clk_in};
            csn_sync_q   <= {csn_sync_q[SYNC_STAGES-2:0], chip_sel_in};
            sync_valid_q <= {sync_valid_q[SYNC_STAGES-2:0], 1'b1};
            sclk_dly_q   <= sclk_s;
            csn_dly_q    <= csn_s;
        end
    end

    state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  hold_q, hold_d;
    logic                   hold_full_q, hold_full_d;
    logic [DATA_WIDTH-1:0]  last_q, last_d;
    logic [DATA_WIDTH-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic                   rise_seen_q, rise_seen_d;
    logic                   armed_q, armed_d;
    logic                   data_q, data_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   abort_q, abort_d;
    logic                   underrun_q, underrun_d;

    logic                   cs_fall, cs_rise, sclk_fall, sclk_rise;
    logic [DATA_WIDTH-1:0]  start_word;

    // A CS fall only counts once CS has been seen high after reset, so a
    // controller still holding CS low across reset cannot start a frame.
    assign cs_fall    = armed_q & csn_dly_q & ~csn_s;
    assign cs_rise    = ~csn_dly_q & csn_s;
    assign sclk_fall  = sclk_dly_q & ~sclk_s;
    assign sclk_rise  = ~sclk_dly_q & sclk_s;
    assign start_word = hold_full_q ? hold_q : last_q;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        last_d      = last_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        rise_seen_d = rise_seen_q;
        armed_d     = armed_q | (sync_valid_q[SYNC_STAGES-1] & csn_s);
        data_d      = data_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        abort_d     = 1'b0;
        underrun_d  = 1'b0;

        // Load uses the registered full flag, so a load coinciding with a
        // frame start lands after the frame has already chosen its word.
        if (sample_valid_in && !hold_full_q) begin
            hold_d      = sample_in;
            hold_full_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    shift_d     = start_word;
                    data_d      = start_word[DATA_WIDTH-1];
                    bit_cnt_d   = CNT_W'(1);
                    rise_seen_d = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = ST_SHIFT;
                    if (hold_full_q) begin
                        last_d      = hold_q;
                        hold_full_d = 1'b0;
                    end else begin
                        underrun_d  = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                if (cs_rise) begin
                    if (bit_cnt_q == CNT_FULL && rise_seen_q) begin
                        done_d  = 1'b1;
                    end else begin
                        abort_d = 1'b1;
                    end
                    data_d  = 1'b0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (sclk_fall) begin
                    rise_seen_d = 1'b0;
                    if (bit_cnt_q < CNT_FULL) begin
                        shift_d   = shift_q << 1;
                        data_d    = shift_q[DATA_WIDTH-2];
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end else begin
                        data_d    = 1'b0;
                    end
                end else if (sclk_rise) begin
                    // Only a rise after the last bit is driven proves it was sampled.
                    rise_seen_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            last_q      <= '0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            rise_seen_q <= 1'b0;
            armed_q     <= 1'b0;
            data_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            last_q      <= last_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            rise_seen_q <= rise_seen_d;
            armed_q     <= armed_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            abort_q     <= abort_d;
            underrun_q  <= underrun_d;
        end
    end

    assign sample_ready_out = ~hold_full_q;
    assign chip_data_out    = data_q;
    assign busy_out         = busy_q;
    assign frame_done_out   = done_q;
    assign frame_abort_out  = abort_q;
    assign underrun_out     = underrun_q;

endmodule

// File: tb/tb_spi_adc_responder.sv
// tb/tb_spi_adc_responder.sv - self-checking bench for spi_adc_responder
module tb_spi_adc_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] sample;
    logic        valid;
    logic        ready;
    logic        sclk;
    logic        csn;
    logic        data;
    logic        busy;
    logic        done_p;
    logic        abort_p;
    logic        under_p;

    always #5 clk = ~clk;

    spi_adc_responder #(.DATA_WIDTH(16), .SYNC_STAGES(2)) dut (
        .clk_in           (clk),
        .rst_n_in         (rst_n),
        .sample_in        (sample),
        .sample_valid_in  (valid),
        .sample_ready_out (ready),
        .chip_clk_in      (sclk),
        .chip_sel_in      (csn),
        .chip_data_out    (data),
        .busy_out         (busy),
        .frame_done_out   (done_p),
        .frame_abort_out  (abort_p),
        .underrun_out     (under_p)
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference model: holding register, last sample, and a sticky source.
    bit          m_full;
    logic [15:0] m_hold;
    logic [15:0] m_last;
    bit          src_pending;
    logic [15:0] src_word;
    bit          src_drv;
    bit          acc_seen;
    logic        acc_busy;

    int  n_done, n_abort, n_und;
    bit  idle_chk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Per-cycle monitor: pulse counting, idle-line checks, source acceptance.
    always @(negedge clk) begin
        if (done_p === 1'b1)  n_done++;
        if (abort_p === 1'b1) n_abort++;
        if (under_p === 1'b1) n_und++;
        if (idle_chk) begin
            chk("idle_data", data, 0);
            chk("idle_busy", busy, 0);
        end
        if (src_drv && valid && ready) begin
            acc_seen = 1'b1;
            acc_busy = busy;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic src_poll();
        if (src_drv && acc_seen) begin
            valid   = 1'b0;
            src_drv = 1'b0;
        end
    endtask

    task automatic load(input logic [15:0] w);
        int t;
        t = 0;
        while (ready !== 1'b1 && t < 50) begin
            cyc(1);
            t++;
        end
        chk("load_ready", ready, 1);
        valid  = 1'b1;
        sample = w;
        cyc(1);
        valid  = 1'b0;
        m_full = 1'b1;
        m_hold = w;
    endtask

    // One frame: each clock is a rise (controller samples) and, except for the
    // last, a following fall. The lead-in fall coincides with the CS fall.
    task automatic run_frame(input int nclk, input int half, input int rst_at,
                             output logic [15:0] wout);
        logic [15:0] w;
        bit          und;
        bit          was_reset;
        int          b_done, b_abort, b_und;
        logic        exp_bit;
        b_done  = n_done;
        b_abort = n_abort;
        b_und   = n_und;
        und     = !m_full;
        w       = m_full ? m_hold : m_last;
        if (m_full) m_last = m_hold;
        m_full  = 1'b0;
        if (src_pending) begin
            m_full      = 1'b1;
            m_hold      = src_word;
            src_pending = 1'b0;
        end
        was_reset = 1'b0;
        wout      = w;
        idle_chk  = 1'b0;
        csn  = 1'b0;
        sclk = 1'b0;
        cyc(half);
        src_poll();
        chk("busy_start", busy, 1);
        for (int k = 1; k <= nclk; k++) begin
            if (k > 1) begin
                sclk = 1'b0;
                cyc(half);
                src_poll();
            end
            exp_bit = (!was_reset && k <= 16) ? w[16-k] : 1'b0;
            chk($sformatf("data_bit%0d", k), data, exp_bit);
            sclk = 1'b1;
            cyc(half);
            src_poll();
            if (k == rst_at) begin
                rst_n = 1'b0;
                cyc(2);
                rst_n   = 1'b1;
                valid   = 1'b0;
                src_drv = 1'b0;
                m_full  = 1'b0;
                m_last  = '0;
                was_reset = 1'b1;
                b_done  = n_done;
                b_abort = n_abort;
                b_und   = n_und;
                und     = 1'b0;
                chk("rst_ready", ready, 1);
                chk("rst_busy", busy, 0);
                chk("rst_data", data, 0);
            end
        end
        csn = 1'b1;
        cyc(half);
        cyc(4);
        chk("frame_done_cnt", n_done - b_done, (!was_reset && nclk >= 16) ? 1 : 0);
        chk("frame_abort_cnt", n_abort - b_abort, (!was_reset && nclk < 16) ? 1 : 0);
        chk("underrun_cnt", n_und - b_und, und ? 1 : 0);
        chk("ready_after", ready, m_full ? 0 : 1);
        idle_chk = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] w;
        rst_n = 1'b0; valid = 1'b0; sample = '0; sclk = 1'b1; csn = 1'b1;
        m_full = 0; m_hold = '0; m_last = '0;
        src_pending = 0; src_word = '0; src_drv = 0; acc_seen = 0; acc_busy = 0;
        n_done = 0; n_abort = 0; n_und = 0; idle_chk = 0;
        cyc(3);
        chk("reset_ready", ready, 1);
        chk("reset_data", data, 0);
        chk("reset_busy", busy, 0);
        chk("reset_pulses", {done_p, abort_p, under_p}, 0);
        rst_n = 1'b1;
        cyc(6);
        idle_chk = 1'b1;

        // T1
        load(16'hA5C3);
        chk("t1_ready_full", ready, 0);
        run_frame(16, 5, 0, w);
        chk("t1_word", w, 16'hA5C3);

        // T2: reset-state underrun sends zero, then a loaded word replays
        rst_n = 1'b0; cyc(2); rst_n = 1'b1; m_full = 0; m_last = '0; cyc(6);
        run_frame(16, 5, 0, w);
        chk("t2_word0", w, 16'h0000);
        load(16'h1234);
        run_frame(16, 5, 0, w);
        chk("t2_word1", w, 16'h1234);
        run_frame(16, 5, 0, w);
        chk("t2_word2", w, 16'h1234);

        // T3: abort after 7 clocks, sample consumed
        load(16'hFFFF);
        run_frame(7, 5, 0, w);
        chk("t3_word0", w, 16'hFFFF);
        run_frame(16, 5, 0, w);
        chk("t3_word1", w, 16'hFFFF);

        // T4: sticky source waits for the frame start
        load(16'h0001);
        src_word = 16'h00FF; src_pending = 1; acc_seen = 0;
        sample = 16'h00FF; valid = 1'b1; src_drv = 1;
        cyc(4);
        chk("t4_ready_held", ready, 0);
        chk("t4_not_accepted", acc_seen, 0);
        run_frame(16, 5, 0, w);
        chk("t4_word0", w, 16'h0001);
        chk("t4_accepted", acc_seen, 1);
        chk("t4_accept_in_frame", acc_busy, 1);
        run_frame(16, 5, 0, w);
        chk("t4_word1", w, 16'h00FF);
        run_frame(16, 4, 0, w);
        chk("t4_word2", w, 16'h00FF);

        // T5: extra clocks read zeros
        load(16'h8001);
        run_frame(18, 5, 0, w);
        chk("t5_word", w, 16'h8001);

        // T6: reset at bit 5 with CS low, then a clean frame
        load(16'h5A5A);
        run_frame(9, 5, 5, w);
        run_frame(16, 5, 0, w);
        chk("t6_word_after", w, 16'h0000);

        // Randomized frames
        for (int i = 0; i < 40; i++) begin
            int nclk;
            if ($urandom_range(0, 1) == 1) load(16'($urandom));
            nclk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 18)) : 16;
            run_frame(nclk, int'($urandom_range(3, 5)), 0, w);
            cyc(int'($urandom_range(0, 6)));
        end

        idle_chk = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
